// File: rtl/lf_pkg.sv
// Shared constants for the Ladner-Fischer pipelined subtractor: default width
// and the number of prefix levels evaluated ahead of the first register stage.
package lf_pkg;

  localparam int LF_N         = 64;
  localparam int LF_LOG2N     = $clog2(LF_N);
  localparam int LF_S1_LEVELS = (LF_LOG2N + 1) / 2;

  // Levels placed before the S1 register: ceil(log2n / 2).
  function automatic int lf_s1_levels(input int log2n);
    return (log2n + 1) / 2;
  endfunction

endpackage

// File: rtl/lf_prefix_level.sv
// One Ladner-Fischer prefix level: bit i with bit LEVEL of its index set merges
// with the most significant bit of the preceding aligned 2^LEVEL block.
module lf_prefix_level #(
  parameter int W     = 64,
  parameter int LEVEL = 0
) (
  input  logic [W-1:0] g_in,
  input  logic [W-1:0] p_in,
  output logic [W-1:0] g_out,
  output logic [W-1:0] p_out
);

  for (genvar i = 0; i < W; i++) begin : g_bit
    if (((i >> LEVEL) & 1) == 1) begin : g_cell
      localparam int J = ((i >> LEVEL) << LEVEL) - 1;
      assign g_out[i] = g_in[i] | (p_in[i] & g_in[J]);
      assign p_out[i] = p_in[i] & p_in[J];
    end else begin : g_pass
      assign g_out[i] = g_in[i];
      assign p_out[i] = p_in[i];
    end
  end

endmodule

// File: rtl/lf_pipelined_subtractor.sv
// Two-stage valid/ready subtractor computing a - b - bin as a + ~b + ~bin with a
// Ladner-Fischer carry network split across the two register stages.
module lf_pipelined_subtractor
  import lf_pkg::*;
#(
  parameter int N = LF_N
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] d,
  output logic         bout,
  output logic         ovf
);

  localparam int L = $clog2(N);
  localparam int S = lf_s1_levels(L);

  logic [N-1:0] g_net [0:L];
  logic [N-1:0] p_net [0:L];
  logic [N-1:0] nb;
  logic [N-1:0] pbit;
  logic [N-1:0] gbit;
  logic         cin;

  logic         valid_s1;
  logic [N-1:0] g_s1;
  logic [N-1:0] p_s1;
  logic [N-1:0] pbit_s1;
  logic         cin_s1;
  logic         a_msb_s1;
  logic         b_msb_s1;

  logic         ready_s1;
  logic         ready_s2;
  logic [N-1:0] carry;
  logic [N-1:0] d_next;
  logic         unused_p_top;

  assign nb   = ~b;
  assign cin  = ~bin;
  assign pbit = a ^ nb;
  assign gbit = a & nb;

  // Carry-in folded into bit 0 so group G[i:0] is directly the carry out of bit i.
  assign g_net[0] = {gbit[N-1:1], gbit[0] | (pbit[0] & cin)};
  assign p_net[0] = pbit;

  for (genvar k = 0; k < L; k++) begin : g_level
    logic [N-1:0] g_src;
    logic [N-1:0] p_src;
    if (k == S) begin : g_from_reg
      assign g_src = g_s1;
      assign p_src = p_s1;
    end else begin : g_from_net
      assign g_src = g_net[k];
      assign p_src = p_net[k];
    end
    lf_prefix_level #(
      .W    (N),
      .LEVEL(k)
    ) u_level (
      .g_in (g_src),
      .p_in (p_src),
      .g_out(g_net[k+1]),
      .p_out(p_net[k+1])
    );
  end

  assign unused_p_top = ^p_net[L];

  assign carry  = {g_net[L][N-2:0], cin_s1};
  assign d_next = pbit_s1 ^ carry;

  assign ready_s2 = !out_valid | out_ready;
  assign ready_s1 = !valid_s1 | ready_s2;
  assign in_ready = ready_s1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_s1 <= 1'b0;
      g_s1     <= '0;
      p_s1     <= '0;
      pbit_s1  <= '0;
      cin_s1   <= 1'b0;
      a_msb_s1 <= 1'b0;
      b_msb_s1 <= 1'b0;
    end else begin
      if (ready_s1) begin
        valid_s1 <= in_valid;
      end
      if (in_valid && ready_s1) begin
        g_s1     <= g_net[S];
        p_s1     <= p_net[S];
        pbit_s1  <= pbit;
        cin_s1   <= cin;
        a_msb_s1 <= a[N-1];
        b_msb_s1 <= b[N-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      d         <= '0;
      bout      <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      if (ready_s2) begin
        out_valid <= valid_s1;
      end
      if (valid_s1 && ready_s2) begin
        d    <= d_next;
        bout <= ~g_net[L][N-1];
        ovf  <= (a_msb_s1 != b_msb_s1) && (d_next[N-1] != a_msb_s1);
      end
    end
  end

endmodule

// File: tb/tb_lf_pipelined_subtractor.sv
// Scoreboard bench for lf_pipelined_subtractor at the default 64-bit width.
module tb_lf_pipelined_subtractor;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] a;
  logic [63:0] b;
  logic        bin;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] d;
  logic        bout;
  logic        ovf;

  int checks = 0;
  int passes = 0;

  // Expected {ovf, bout, d}, oldest first.
  logic [65:0] exp_q[$];

  lf_pipelined_subtractor #(.N(64)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .bin      (bin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .d        (d),
    .bout     (bout),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  function automatic logic [65:0] model(input logic [63:0] ma, input logic [63:0] mb,
                                        input logic mbin);
    logic [64:0] t;
    logic        o;
    t = {1'b0, ma} - {1'b0, mb} - {64'd0, mbin};
    o = (ma[63] != mb[63]) && (t[63] != ma[63]);
    return {o, t[64], t[63:0]};
  endfunction

  function automatic logic [63:0] rand_op();
    case ($urandom_range(0, 7))
      0:       return 64'h0;
      1:       return 64'hFFFF_FFFF_FFFF_FFFF;
      2:       return 64'h8000_0000_0000_0000;
      3:       return 64'h7FFF_FFFF_FFFF_FFFF;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({out_valid, bout, ovf, d} !== 67'd0)
      $display("FAIL reset_outputs: got %h expected 0", {out_valid, bout, ovf, d});
    else passes++;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    else passes++;
  endtask

  task automatic test_vector(input string name, input logic [63:0] va, input logic [63:0] vb,
                             input logic vbin, input logic [63:0] ed, input logic eb,
                             input logic eo);
    logic [65:0] exp;
    out_ready = 1'b1;
    a = va; b = vb; bin = vbin; in_valid = 1'b1;
    exp_q.push_back({eo, eb, ed});
    @(posedge clk);
    #1;
    in_valid = 1'b0; a = {$urandom, $urandom}; b = {$urandom, $urandom}; bin = 1'b1;
    checks++;
    if (out_valid !== 1'b0) $display("FAIL %s_early: out_valid %b expected 0", name, out_valid);
    else passes++;
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1) $display("FAIL %s_latency: out_valid %b expected 1", name, out_valid);
    else passes++;
    exp = exp_q.pop_front();
    checks++;
    if ({ovf, bout, d} !== exp)
      $display("FAIL %s_result: got %h expected %h", name, {ovf, bout, d}, exp);
    else passes++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    int idx;
    int got_n;
    logic [65:0] exp;
    idx = 0;
    got_n = 0;
    for (int cyc = 0; cyc < 16; cyc++) begin
      out_ready = (cyc >= 4);
      if (idx < 3) begin
        in_valid = 1'b1;
        a = 64'd1000 * (idx + 1);
        b = 64'd7 + idx;
        bin = idx[0];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (cyc == 2 || cyc == 3) begin
        checks++;
        if (in_ready !== 1'b0) $display("FAIL b2b_stall_ready: got %b expected 0", in_ready);
        else passes++;
        checks++;
        if (exp_q.size() == 0 || out_valid !== 1'b1 || {ovf, bout, d} !== exp_q[0])
          $display("FAIL b2b_hold: valid %b data %h", out_valid, {ovf, bout, d});
        else passes++;
      end
      if (cyc == 4) begin
        checks++;
        if ({in_ready, out_valid} !== 2'b11)
          $display("FAIL b2b_accept_retire: got %b expected 11", {in_ready, out_valid});
        else passes++;
      end
      if (out_valid && out_ready) begin
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : 66'h0;
        checks++;
        if ({ovf, bout, d} !== exp)
          $display("FAIL b2b_order: got %h expected %h", {ovf, bout, d}, exp);
        else passes++;
        got_n++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(a, b, bin));
        idx++;
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (got_n !== 3) $display("FAIL b2b_count: got %0d expected 3", got_n);
    else passes++;
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; a = 64'd50 + i; b = 64'd3; bin = 1'b0;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1) $display("FAIL rstmid_full: out_valid %b expected 1", out_valid);
    else passes++;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, d} !== 65'd0)
      $display("FAIL rstmid_async: got %h expected 0", {out_valid, d});
    else passes++;
    #2;
    rst_n = 1'b1;
    exp_q.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0) $display("FAIL rstmid_stale: out_valid %b expected 0", out_valid);
      else passes++;
    end
    checks++;
    if (in_ready !== 1'b1) $display("FAIL rstmid_ready: got %b expected 1", in_ready);
    else passes++;
  endtask

  task automatic test_random();
    int sent;
    int cyc;
    int bad;
    logic        held_v;
    logic [65:0] held;
    logic [65:0] exp;
    sent = 0;
    cyc = 0;
    bad = 0;
    held_v = 1'b0;
    held = '0;
    while ((sent < 10000 || exp_q.size() != 0) && cyc < 60000) begin
      if (sent < 10000 && $urandom_range(0, 3) != 0) begin
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      a = rand_op(); b = rand_op(); bin = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (held_v) begin
        checks++;
        if (out_valid !== 1'b1 || {ovf, bout, d} !== held) begin
          bad++;
          if (bad < 10) $display("FAIL rand_hold: got %b/%h expected 1/%h",
                                 out_valid, {ovf, bout, d}, held);
        end else passes++;
      end
      held_v = out_valid && !out_ready;
      held = {ovf, bout, d};
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          bad++;
          if (bad < 10) $display("FAIL rand_extra: got %h expected none", {ovf, bout, d});
        end else begin
          exp = exp_q.pop_front();
          if ({ovf, bout, d} !== exp) begin
            bad++;
            if (bad < 10) $display("FAIL rand_result: got %h expected %h", {ovf, bout, d}, exp);
          end else passes++;
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(a, b, bin));
        sent++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid = 1'b0;
    checks++;
    if (sent !== 10000 || exp_q.size() != 0)
      $display("FAIL rand_drain: sent %0d left %0d expected 10000 and 0", sent, exp_q.size());
    else passes++;
  endtask

  initial begin
    clk = 1'b0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    bin = 1'b0;
    test_reset();
    test_vector("sub_pos", 64'd15, 64'd10, 1'b0, 64'd5, 1'b0, 1'b0);
    test_vector("sub_neg", 64'd10, 64'd15, 1'b0, 64'hFFFF_FFFF_FFFF_FFFB, 1'b1, 1'b0);
    test_vector("borrow_in", 64'd0, 64'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
    test_vector("ovf_min", 64'h8000_0000_0000_0000, 64'd1, 1'b0,
                64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1);
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/lf_pipelined_subtractor.md
LF_PIPELINED_SUBTRACTOR -- requirements
Module: lf_pipelined_subtractor

Interface
REQ-001 SHALL have parameter N, default 64, meaning operand and result width (power of two, 8..128).
REQ-002 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-004 SHALL have port in_valid, input, 1, operand set a/b/bin valid.
REQ-005 SHALL have port in_ready, output, 1, block accepts operands this cycle.
REQ-006 SHALL have port a, input, N, minuend (unsigned or two's complement).
REQ-007 SHALL have port b, input, N, subtrahend.
REQ-008 SHALL have port bin, input, 1, borrow-in.
REQ-009 SHALL have port out_valid, output, 1, result valid.
REQ-010 SHALL have port out_ready, input, 1, downstream accepts result.
REQ-011 SHALL have port d, output, N, difference.
REQ-012 SHALL have port bout, output, 1, borrow-out.
REQ-013 SHALL have port ovf, output, 1, signed overflow.

Function
REQ-014 SHALL compute d = (a - b - bin) mod 2^N, formed as a + ~b + ~bin through a Ladner-Fischer prefix carry network.
REQ-015 SHALL set bout = 1 iff a < b + bin (unsigned), i.e. inverse of the prefix-network carry-out.
REQ-016 SHALL set ovf = 1 iff a[N-1] != b[N-1] and d[N-1] != a[N-1].
REQ-017 SHALL implement two register stages: S1 holds group G/P after the first ceil(log2(N)/2) prefix levels plus p and carry-in; S2 holds d, bout, ovf.
REQ-018 SHALL have latency 2: a transfer (in_valid & in_ready) at edge k presents its result with out_valid at edge k+2 when out_ready stays high.
REQ-019 SHALL sustain one transfer per cycle when out_ready is held high.
REQ-020 SHALL advance each stage when it is empty or the next stage advances: ready_S2 = !valid_S2 | out_ready; ready_S1 = !valid_S1 | ready_S2; in_ready = ready_S1.
REQ-021 SHALL hold d, bout, ovf stable while out_valid & !out_ready.
REQ-022 SHALL preserve result order; no drop or duplication under any backpressure pattern.
REQ-023 SHALL make in_ready depend on out_ready combinationally only through REQ-020 (no combinational path from in_valid to in_ready).
REQ-024 SHALL accept and retire in the same cycle when both pipeline stages are full and out_ready = 1.
REQ-025 SHALL ignore a, b, bin when in_valid = 0 or in_ready = 0.

Reset
REQ-026 SHALL, on rst_n low, asynchronously clear both stage valid flags, out_valid = 0, d = 0, bout = 0, ovf = 0.
REQ-027 SHALL drive in_ready = 1 one cycle after rst_n deasserts and discard in-flight operands on reset mid-operation.

Structure
REQ-028 SHALL place default N, LOG2N and the S1 level split constant in shared package lf_pkg.
REQ-029 SHALL use one sub-module lf_prefix_level (one Ladner-Fischer level of (G,P) combine cells, parameterised by width and level index), instantiated per level by generate.

Verification
REQ-030 SHALL check a=15, b=10, bin=0 -> d=5, bout=0, ovf=0, after exactly 2 cycles.
REQ-031 SHALL check a=10, b=15, bin=0 -> d=0xFFFF_FFFF_FFFF_FFFB, bout=1, ovf=0.
REQ-032 SHALL check a=0, b=0, bin=1 -> d=all ones, bout=1; and a=0x8000_0000_0000_0000, b=1, bin=0 -> d=0x7FFF_FFFF_FFFF_FFFF, ovf=1, bout=0.
REQ-033 SHALL check back-to-back 3 transfers with out_ready low 4 cycles -> in_ready low after 2 held, results emerge in order once out_ready rises.
REQ-034 SHALL check rst_n pulsed low with both stages full -> out_valid low immediately, no stale result after release.
REQ-035 SHALL check 10k random operands with random valid/ready against a reference model {bout,d} = {1'b0,a} - b - bin.
